port_io_bus_master: RTL and testbench
=====================================

Name: port_io_bus_master

Overview:
- Host-side controller that sequences the time-multiplexed 8-bit port I/O bus.
- Holds per-port direction and output shadow registers, plus captured input values.
- Runs a repeating slot frame of SYNC, then DIR/WRITE/READ for each port: the master drives direction and output bytes and samples the peripheral's input byte.
- A simple register interface gives a CPU/bridge random access to all ports without knowing the bus timing.

Parameters:
- NPORTS, 10: number of ports in the frame (1..15).
- AW, 6: host address width; register map is 4 addresses per port plus global registers at 0x3C..0x3F.

Ports:
- port_clk  in  1  clock
- port_rst  in  1  synchronous active-high reset
- host_addr  in  AW  register address
- host_wr  in  1  write strobe, one cycle
- host_wdata  in  8  write data
- host_rd  in  1  read strobe, one cycle
- host_rdata  out  8  read data, valid with host_rvalid
- host_rvalid  out  1  read response pulse
- bus_dout  out  8  byte driven onto shared data bus
- bus_oe  out  1  1 = master drives bus (tri-state resolved at top level)
- bus_din  in  8  bus value as seen at pins
- slot_sync  out  1  high during SYNC slot; peripheral realigns its slot counter
- busy  out  1  frame in progress

Behaviour:
- Reset values:
  - State IDLE; bus_oe=0, bus_dout=0, slot_sync=0, busy=0, host_rvalid=0, host_rdata=0.
  - All DIR/OUT shadow and active registers 0; IN registers 0; CTRL=0; frame_cnt=0.
- Register map, per port p at base p*4:
  - +0 DIR (rw shadow)
  - +1 OUT (rw shadow)
  - +2 IN (ro)
  - +3 reserved
- Global registers:
  - 0x3C CTRL: bit0 run, bit1 oneshot.
  - 0x3D FRAME_CNT (ro, 8-bit, wraps 255->0).
  - 0x3E CHG (optional feature).
- Unmapped addresses and p>=NPORTS: reads return 0, writes ignored. Writes to ro registers are ignored.
- Host read latency: exactly 1 cycle (registered). host_rd and host_wr in the same cycle: write performed, read returns the pre-write value.
- FSM states: IDLE, SYNC, DIR, WRITE, READ; 3-bit slot type plus 4-bit port index p.
- Transitions:
  - IDLE->SYNC when run=1 or oneshot=1.
  - SYNC->DIR(p=0); DIR->WRITE->READ.
  - READ->DIR(p+1) if p<NPORTS-1, else end-of-frame.
  - End-of-frame: increment frame_cnt, clear oneshot; go to SYNC if run=1, else IDLE.
- Frame length: 1+3*NPORTS cycles; each slot lasts 1 cycle.
- SYNC slot:
  - slot_sync=1, bus_oe=0.
  - Active DIR/OUT for all ports loaded from shadow, so host writes only take effect at a frame boundary. This makes updates atomic per frame.
- DIR slot: bus_oe=1, bus_dout=active_dir[p].
- WRITE slot: bus_oe=1, bus_dout=active_out[p].
- READ slot: bus_oe=0; IN[p] <= bus_din at the clock edge ending the slot.
- Outputs bus_oe, bus_dout and slot_sync are registered, aligned to the slot they belong to.
- busy=1 in every state except IDLE.
- Clearing run mid-frame: the current frame completes, then IDLE.
- Host write to a shadow register during SYNC: the new value is not captured; it applies next frame.
- port_rst mid-frame: immediate return to reset values; bus released on the next cycle.

Optional Feature:
- Macro: PORT_IO_CHANGE_IRQ_EN.
- When defined:
  - Each READ slot compares bus_din to the previous IN[p]; a difference sets sticky CHG[p].
  - CHG is readable at 0x3E/0x3F (bits 0..7 / 8..14); writing 1 clears a bit. Set wins over a same-cycle clear.
  - Extra output port irq = |CHG, registered.
  - The first frame after reset does not set CHG.
- When undefined: no irq port, 0x3E/0x3F read 0, no compare logic.

Decomposition:
- Package port_io_pkg:
  - slot-type enum (IDLE, SYNC, DIR, WRITE, READ);
  - register offsets (DIR=0, OUT=1, IN=2);
  - global addresses 0x3C..0x3F;
  - CTRL bit positions.
- Sub-module port_io_slot_seq: the FSM plus port index counter. Outputs slot type, p, slot_sync, and an end-of-frame pulse.
- Register file and host interface stay in the top.

Test Plan:
- Reset, then write DIR0=0xFF, OUT0=0xA5, CTRL=0x01 -> slot_sync high 1 cycle; next cycle bus_oe=1 dout=0xFF; next dout=0xA5; next bus_oe=0.
- NPORTS=10, run=1 -> SYNC repeats every 31 cycles; FRAME_CNT reads 3 after 3 frames; after 256 frames it wraps to 0.
- Drive bus_din=0x3C during the port2 READ slot -> a host read of addr 0x0A returns 0x3C, with host_rvalid exactly 1 cycle after host_rd.
- Write OUT1=0x55 mid-frame after the port1 WRITE slot -> 0x55 does not appear until the next frame's port1 WRITE slot; writing during SYNC defers one further frame.
- oneshot=1 with run=0 -> exactly one frame, then IDLE with busy=0 and oneshot reads 0. Clearing run at p=4 -> frame completes through p=9 READ, then IDLE.
- With PORT_IO_CHANGE_IRQ_EN: port3 input toggles 0x00->0x01 -> CHG bit3 set, irq=1; write 0x08 to 0x3E -> irq=0. Assert port_rst mid-frame -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/port_io_pkg.sv
// Shared types and constants for the port I/O bus master.
// Optional change-detect/IRQ feature is selected with PORT_IO_CHANGE_IRQ_EN.
package port_io_pkg;

    // One bus slot per cycle; IDLE only between frames.
    typedef enum logic [2:0] {
        SlotIdle  = 3'd0,
        SlotSync  = 3'd1,
        SlotDir   = 3'd2,
        SlotWrite = 3'd3,
        SlotRead  = 3'd4
    } slot_e;

    // Per-port register offsets within the 4-address port window.
    localparam logic [1:0] OffDir = 2'd0;
    localparam logic [1:0] OffOut = 2'd1;
    localparam logic [1:0] OffIn  = 2'd2;

    // Global register addresses.
    localparam int unsigned AddrCtrl     = 'h3C;
    localparam int unsigned AddrFrameCnt = 'h3D;
    localparam int unsigned AddrChgLo    = 'h3E;
    localparam int unsigned AddrChgHi    = 'h3F;

    // CTRL bit positions.
    localparam int unsigned CtrlRunBit     = 0;
    localparam int unsigned CtrlOneshotBit = 1;

endpackage

// File: rtl/port_io_slot_seq.sv
// Slot sequencer: SYNC, then DIR/WRITE/READ for each port, repeating while run is set.
// Exposes next-state so the top can register bus outputs aligned to their slot.
module port_io_slot_seq import port_io_pkg::*; #(
    parameter int unsigned NPORTS = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       run_i,
    input  logic       oneshot_i,
    output slot_e      slot_o,
    output logic [3:0] port_o,
    output slot_e      slot_next_o,
    output logic [3:0] port_next_o,
    output logic       slot_sync_o,
    output logic       eof_o
);

    localparam logic [3:0] LastPort = 4'(NPORTS - 1);

    slot_e      slot_q, slot_d;
    logic [3:0] port_q, port_d;
    logic       slot_sync_q;
    logic       eof;

    // Next-state logic for slot type and port index.
    always_comb begin
        slot_d = slot_q;
        port_d = port_q;
        eof    = 1'b0;
        unique case (slot_q)
            SlotIdle:  if (run_i || oneshot_i) slot_d = SlotSync;
            SlotSync: begin
                slot_d = SlotDir;
                port_d = '0;
            end
            SlotDir:   slot_d = SlotWrite;
            SlotWrite: slot_d = SlotRead;
            SlotRead: begin
                if (port_q < LastPort) begin
                    slot_d = SlotDir;
                    port_d = port_q + 4'd1;
                end else begin
                    eof    = 1'b1;
                    slot_d = run_i ? SlotSync : SlotIdle;
                end
            end
            default:   slot_d = SlotIdle;
        endcase
    end

    // State registers; slot_sync is registered alongside the slot it marks.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q      <= SlotIdle;
            port_q      <= '0;
            slot_sync_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            port_q      <= port_d;
            slot_sync_q <= (slot_d == SlotSync);
        end
    end

    assign slot_o      = slot_q;
    assign port_o      = port_q;
    assign slot_next_o = slot_d;
    assign port_next_o = port_d;
    assign slot_sync_o = slot_sync_q;
    assign eof_o       = eof;

endmodule

// File: rtl/port_io_bus_master.sv
// Port I/O bus master: host register file, frame-atomic shadow/active registers and
// registered bus drivers. Define PORT_IO_CHANGE_IRQ_EN for sticky input-change flags and irq.
module port_io_bus_master import port_io_pkg::*; #(
    parameter int unsigned NPORTS = 10,
    parameter int unsigned AW     = 6
) (
    input  logic          port_clk,
    input  logic          port_rst,
    input  logic [AW-1:0] host_addr,
    input  logic          host_wr,
    input  logic [7:0]    host_wdata,
    input  logic          host_rd,
    output logic [7:0]    host_rdata,
    output logic          host_rvalid,
    output logic [7:0]    bus_dout,
    output logic          bus_oe,
    input  logic [7:0]    bus_din,
    output logic          slot_sync,
`ifdef PORT_IO_CHANGE_IRQ_EN
    output logic          irq,
`endif
    output logic          busy
);

    slot_e      slot, slot_nxt;
    logic [3:0] port_idx, port_nxt;
    logic       eof;

    logic [7:0] dir_sh_q [NPORTS];
    logic [7:0] dir_sh_d [NPORTS];
    logic [7:0] out_sh_q [NPORTS];
    logic [7:0] out_sh_d [NPORTS];
    logic [7:0] dir_act_q[NPORTS];
    logic [7:0] dir_act_d[NPORTS];
    logic [7:0] out_act_q[NPORTS];
    logic [7:0] out_act_d[NPORTS];
    logic [7:0] in_q     [NPORTS];
    logic [7:0] in_d     [NPORTS];

    logic       run_q, run_d, oneshot_q, oneshot_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [7:0] rdata_q, rdata_d, rd_val;
    logic       rvalid_q;
    logic       bus_oe_q, bus_oe_d;
    logic [7:0] bus_dout_q, bus_dout_d;

    logic [AW-3:0] hport;
    logic [1:0]    hoff;
    logic          port_hit;

    assign hport    = host_addr[AW-1:2];
    assign hoff     = host_addr[1:0];
    assign port_hit = 32'(hport) < NPORTS;

    port_io_slot_seq #(
        .NPORTS (NPORTS)
    ) u_seq (
        .clk_i       (port_clk),
        .rst_i       (port_rst),
        .run_i       (run_q),
        .oneshot_i   (oneshot_q),
        .slot_o      (slot),
        .port_o      (port_idx),
        .slot_next_o (slot_nxt),
        .port_next_o (port_nxt),
        .slot_sync_o (slot_sync),
        .eof_o       (eof)
    );

    // Register file next-state: host writes, frame-boundary active load, input capture.
    always_comb begin
        dir_sh_d    = dir_sh_q;
        out_sh_d    = out_sh_q;
        dir_act_d   = dir_act_q;
        out_act_d   = out_act_q;
        in_d        = in_q;
        run_d       = run_q;
        oneshot_d   = oneshot_q;
        frame_cnt_d = frame_cnt_q;
        if (eof) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            oneshot_d   = 1'b0;
        end
        if (host_wr) begin
            if (port_hit) begin
                for (int unsigned i = 0; i < NPORTS; i++) begin
                    if (32'(hport) == i) begin
                        if (hoff == OffDir) dir_sh_d[i] = host_wdata;
                        if (hoff == OffOut) out_sh_d[i] = host_wdata;
                    end
                end
            end
            if (32'(host_addr) == AddrCtrl) begin
                run_d     = host_wdata[CtrlRunBit];
                oneshot_d = host_wdata[CtrlOneshotBit];
            end
        end
        // Loading on entry to SYNC makes a write issued during SYNC wait one more frame.
        if (slot_nxt == SlotSync) begin
            dir_act_d = dir_sh_q;
            out_act_d = out_sh_q;
        end
        if (slot == SlotRead) begin
            for (int unsigned i = 0; i < NPORTS; i++) begin
                if (port_idx == 4'(i)) in_d[i] = bus_din;
            end
        end
    end

    // Bus drive values for the upcoming slot, registered so they line up with it.
    always_comb begin
        bus_oe_d   = 1'b0;
        bus_dout_d = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (port_nxt == 4'(i)) begin
                if (slot_nxt == SlotDir) begin
                    bus_oe_d   = 1'b1;
                    bus_dout_d = dir_act_q[i];
                end else if (slot_nxt == SlotWrite) begin
                    bus_oe_d   = 1'b1;
                    bus_dout_d = out_act_q[i];
                end
            end
        end
    end

`ifdef PORT_IO_CHANGE_IRQ_EN
    logic [NPORTS-1:0] chg_q, chg_d;
    logic [15:0]       chg_wide, chg_clr;
    logic              seen_q, seen_d;
    logic              irq_q;

    assign chg_wide = 16'(chg_q);

    // Sticky change flags: write-1-to-clear, a same-cycle set takes priority.
    always_comb begin
        chg_d   = chg_q;
        chg_clr = '0;
        seen_d  = seen_q | eof;
        if (host_wr && 32'(host_addr) == AddrChgLo) chg_clr[7:0]  = host_wdata;
        if (host_wr && 32'(host_addr) == AddrChgHi) chg_clr[14:8] = host_wdata[6:0];
        chg_d = chg_q & ~chg_clr[NPORTS-1:0];
        // Inputs of the first frame after reset are the baseline, not a change.
        if (slot == SlotRead && seen_q) begin
            for (int unsigned i = 0; i < NPORTS; i++) begin
                if (port_idx == 4'(i) && bus_din != in_q[i]) chg_d[i] = 1'b1;
            end
        end
    end

    // Change-flag and irq registers.
    always_ff @(posedge port_clk) begin
        if (port_rst) begin
            chg_q  <= '0;
            seen_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            chg_q  <= chg_d;
            seen_q <= seen_d;
            irq_q  <= |chg_d;
        end
    end

    assign irq = irq_q;
`endif

    // Host read mux; registered below for a fixed one-cycle latency.
    always_comb begin
        rd_val = '0;
        if (port_hit) begin
            for (int unsigned i = 0; i < NPORTS; i++) begin
                if (32'(hport) == i) begin
                    if (hoff == OffDir) rd_val = dir_sh_q[i];
                    if (hoff == OffOut) rd_val = out_sh_q[i];
                    if (hoff == OffIn)  rd_val = in_q[i];
                end
            end
        end
        if (32'(host_addr) == AddrCtrl)     rd_val = {6'b0, oneshot_q, run_q};
        if (32'(host_addr) == AddrFrameCnt) rd_val = frame_cnt_q;
`ifdef PORT_IO_CHANGE_IRQ_EN
        if (32'(host_addr) == AddrChgLo)    rd_val = chg_wide[7:0];
        if (32'(host_addr) == AddrChgHi)    rd_val = chg_wide[15:8];
`endif
        rdata_d = host_rd ? rd_val : rdata_q;
    end

    // All architectural state, synchronously reset.
    always_ff @(posedge port_clk) begin
        if (port_rst) begin
            for (int unsigned i = 0; i < NPORTS; i++) begin
                dir_sh_q[i]  <= '0;
                out_sh_q[i]  <= '0;
                dir_act_q[i] <= '0;
                out_act_q[i] <= '0;
                in_q[i]      <= '0;
            end
            run_q       <= 1'b0;
            oneshot_q   <= 1'b0;
            frame_cnt_q <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            bus_oe_q    <= 1'b0;
            bus_dout_q  <= '0;
        end else begin
            dir_sh_q    <= dir_sh_d;
            out_sh_q    <= out_sh_d;
            dir_act_q   <= dir_act_d;
            out_act_q   <= out_act_d;
            in_q        <= in_d;
            run_q       <= run_d;
            oneshot_q   <= oneshot_d;
            frame_cnt_q <= frame_cnt_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= host_rd;
            bus_oe_q    <= bus_oe_d;
            bus_dout_q  <= bus_dout_d;
        end
    end

    assign host_rdata  = rdata_q;
    assign host_rvalid = rvalid_q;
    assign bus_oe      = bus_oe_q;
    assign bus_dout    = bus_dout_q;
    assign busy        = (slot != SlotIdle);

endmodule

// File: tb/tb_port_io_bus_master.sv
// Self-checking bench for port_io_bus_master: randomized frames against a slot-arithmetic model.
module tb_port_io_bus_master;

    localparam int unsigned NPORTS = 10;
    localparam int unsigned AW     = 6;
    localparam int          FRAME  = 1 + 3 * NPORTS;
    localparam logic [AW-1:0] A_CTRL = 6'h3C;
    localparam logic [AW-1:0] A_FCNT = 6'h3D;
    localparam logic [AW-1:0] A_CHG  = 6'h3E;

    logic          port_clk = 1'b0;
    logic          port_rst = 1'b1;
    logic [AW-1:0] host_addr = '0;
    logic          host_wr = 1'b0;
    logic [7:0]    host_wdata = '0;
    logic          host_rd = 1'b0;
    logic [7:0]    host_rdata;
    logic          host_rvalid;
    logic [7:0]    bus_dout;
    logic          bus_oe;
    logic [7:0]    bus_din = '0;
    logic          slot_sync;
    logic          busy;
`ifdef PORT_IO_CHANGE_IRQ_EN
    logic          irq;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state.
    logic [7:0] dir_m[NPORTS], out_m[NPORTS], in_m[NPORTS], act_dir_m[NPORTS], act_out_m[NPORTS];
    int         frames_m = 0;

    port_io_bus_master #(.NPORTS(NPORTS), .AW(AW)) dut (
        .port_clk    (port_clk),
        .port_rst    (port_rst),
        .host_addr   (host_addr),
        .host_wr     (host_wr),
        .host_wdata  (host_wdata),
        .host_rd     (host_rd),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .bus_dout    (bus_dout),
        .bus_oe      (bus_oe),
        .bus_din     (bus_din),
        .slot_sync   (slot_sync),
`ifdef PORT_IO_CHANGE_IRQ_EN
        .irq         (irq),
`endif
        .busy        (busy)
    );

    always #5 port_clk = ~port_clk;

    task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge port_clk);
        host_addr = a; host_wdata = d; host_wr = 1'b1;
        @(negedge port_clk);
        host_wr = 1'b0;
    endtask

    task automatic host_read(input logic [AW-1:0] a, output logic [7:0] d, output logic v);
        @(negedge port_clk);
        host_addr = a; host_rd = 1'b1;
        @(negedge port_clk);
        host_rd = 1'b0;
        d = host_rdata; v = host_rvalid;
    endtask

    task automatic test_reset();
        logic [7:0] d; logic v;
        port_rst = 1'b1;
        repeat (3) @(negedge port_clk);
        total_cnt++; if ({bus_oe, slot_sync, busy, host_rvalid} !== 4'b0)
            $display("FAIL reset_ctl got=%b exp=0000", {bus_oe, slot_sync, busy, host_rvalid});
        else pass_cnt++;
        total_cnt++; if ({bus_dout, host_rdata} !== 16'h0)
            $display("FAIL reset_data got=%h exp=0000", {bus_dout, host_rdata});
        else pass_cnt++;
        port_rst = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin dir_m[p] = 0; out_m[p] = 0; in_m[p] = 0; end
        frames_m = 0;
        host_read(A_CTRL, d, v);
        total_cnt++; if (d !== 8'h00) $display("FAIL reset_ctrl got=%h exp=00", d); else pass_cnt++;
        host_read(A_FCNT, d, v);
        total_cnt++; if (d !== 8'h00) $display("FAIL reset_fcnt got=%h exp=00", d); else pass_cnt++;
    endtask

    task automatic test_regs();
        logic [7:0] d, nd; logic v;
        int p, off;
        for (int i = 0; i < 8; i++) begin
            p = $urandom_range(0, NPORTS - 1); off = $urandom_range(0, 1); nd = 8'($urandom);
            host_write(AW'(p * 4 + off), nd);
            if (off == 0) dir_m[p] = nd; else out_m[p] = nd;
            host_read(AW'(p * 4 + off), d, v);
            total_cnt++; if (d !== nd || v !== 1'b1)
                $display("FAIL reg_rw p=%0d off=%0d got=%h/%b exp=%h/1", p, off, d, v, nd);
            else pass_cnt++;
        end
        // Read and write in the same cycle: read sees the old value.
        nd = ~out_m[0];
        @(negedge port_clk);
        host_addr = AW'(1); host_wdata = nd; host_wr = 1'b1; host_rd = 1'b1;
        @(negedge port_clk);
        host_wr = 1'b0; host_rd = 1'b0;
        total_cnt++; if (host_rdata !== out_m[0])
            $display("FAIL rd_wr_same got=%h exp=%h", host_rdata, out_m[0]);
        else pass_cnt++;
        out_m[0] = nd;
        @(negedge port_clk);
        total_cnt++; if (host_rvalid !== 1'b0)
            $display("FAIL rvalid_width got=%b exp=0", host_rvalid);
        else pass_cnt++;
        host_read(AW'(1), d, v);
        total_cnt++; if (d !== nd) $display("FAIL rd_after_wr got=%h exp=%h", d, nd); else pass_cnt++;
        // Read-only, reserved and unmapped locations.
        host_write(AW'(2), 8'h99);  host_read(AW'(2), d, v);
        total_cnt++; if (d !== 8'h00) $display("FAIL in_ro got=%h exp=00", d); else pass_cnt++;
        host_write(AW'(7), 8'h77);  host_read(AW'(7), d, v);
        total_cnt++; if (d !== 8'h00) $display("FAIL reserved got=%h exp=00", d); else pass_cnt++;
        host_write(6'h28, 8'hAB);   host_read(6'h28, d, v);
        total_cnt++; if (d !== 8'h00) $display("FAIL unmapped got=%h exp=00", d); else pass_cnt++;
        host_write(A_FCNT, 8'h77);  host_read(A_FCNT, d, v);
        total_cnt++; if (d !== 8'h00) $display("FAIL fcnt_ro got=%h exp=00", d); else pass_cnt++;
        host_read(A_CHG, d, v);
        total_cnt++; if (d !== 8'h00) $display("FAIL chg_idle got=%h exp=00", d); else pass_cnt++;
    endtask

    task automatic test_frames();
        logic [7:0] d, exp_dout; logic v, exp_oe, exp_sync, exp_busy;
        int f, k, p, t, rp;
        for (int i = 0; i < NPORTS; i++) begin
            dir_m[i] = (i == 0) ? 8'hFF : 8'($urandom);
            out_m[i] = (i == 0) ? 8'hA5 : 8'($urandom);
            host_write(AW'(i * 4), dir_m[i]);
            host_write(AW'(i * 4 + 1), out_m[i]);
        end
        host_write(A_CTRL, 8'h01);
        for (int c = 0; c < 4 * FRAME + 2; c++) begin
            @(negedge port_clk);
            host_wr = 1'b0;
            f = c / FRAME; k = c % FRAME; p = (k - 1) / 3; t = (k - 1) % 3;
            exp_sync = 0; exp_oe = 0; exp_dout = 0; exp_busy = (f < 4);
            if (f < 4 && k == 0) begin
                exp_sync = 1;
                act_dir_m = dir_m; act_out_m = out_m;
            end else if (f < 4) begin
                exp_oe   = (t < 2);
                exp_dout = (t == 0) ? act_dir_m[p] : (t == 1) ? act_out_m[p] : 8'h00;
            end
            total_cnt++; if ({slot_sync, busy, bus_oe} !== {exp_sync, exp_busy, exp_oe})
                $display("FAIL frame_ctl c=%0d got=%b exp=%b", c, {slot_sync, busy, bus_oe},
                         {exp_sync, exp_busy, exp_oe});
            else pass_cnt++;
            total_cnt++; if (bus_dout !== exp_dout)
                $display("FAIL frame_dout c=%0d got=%h exp=%h", c, bus_dout, exp_dout);
            else pass_cnt++;
            bus_din = 8'($urandom);
            if (f < 4 && k > 0 && t == 2) begin
                if (f == 3 && p == 2) bus_din = 8'h3C;
                in_m[p] = bus_din;
            end
            if (f == 3 && k == 13) begin
                host_addr = A_CTRL; host_wdata = 8'h00; host_wr = 1'b1;
            end else if (f < 3 && k != FRAME - 1 && $urandom_range(0, 3) == 0) begin
                rp = $urandom_range(0, NPORTS - 1);
                host_wdata = 8'($urandom); host_wr = 1'b1;
                if ($urandom_range(0, 1) == 0) begin
                    host_addr = AW'(rp * 4); dir_m[rp] = host_wdata;
                end else begin
                    host_addr = AW'(rp * 4 + 1); out_m[rp] = host_wdata;
                end
            end
        end
        frames_m += 4;
        for (int i = 0; i < NPORTS; i++) begin
            host_read(AW'(i * 4 + 2), d, v);
            total_cnt++; if (d !== in_m[i] || v !== 1'b1)
                $display("FAIL in_capture p=%0d got=%h/%b exp=%h/1", i, d, v, in_m[i]);
            else pass_cnt++;
        end
        host_read(A_FCNT, d, v);
        total_cnt++; if (d !== 8'(frames_m))
            $display("FAIL frame_cnt got=%h exp=%h", d, 8'(frames_m));
        else pass_cnt++;
    endtask

    task automatic test_deferred();
        logic [7:0] old1;
        old1 = out_m[1];
        host_write(A_CTRL, 8'h01);
        for (int c = 0; c < 4 * FRAME + 2; c++) begin
            @(negedge port_clk);
            host_wr = 1'b0;
            if (c == 5 || c == FRAME + 5 || c == 2 * FRAME + 5 || c == 3 * FRAME + 5) begin
                total_cnt++;
                if (bus_dout !== ((c == 5) ? old1 : (c == 3 * FRAME + 5) ? 8'h66 : 8'h55))
                    $display("FAIL deferred_out c=%0d got=%h", c, bus_dout);
                else pass_cnt++;
            end
            if (c == 4 * FRAME + 1) begin
                total_cnt++; if (busy !== 1'b0) $display("FAIL deferred_idle got=%b exp=0", busy);
                else pass_cnt++;
            end
            if (c == 10)             begin host_addr = AW'(5); host_wdata = 8'h55; host_wr = 1; end
            if (c == 2 * FRAME)      begin host_addr = AW'(5); host_wdata = 8'h66; host_wr = 1; end
            if (c == 3 * FRAME + 12) begin host_addr = A_CTRL; host_wdata = 8'h00; host_wr = 1; end
        end
        out_m[1] = 8'h66;
        frames_m += 4;
    endtask

    task automatic test_oneshot();
        logic [7:0] d; logic v;
        int busy_cnt = 0, sync_cnt = 0;
        host_write(A_CTRL, 8'h02);
        for (int c = 0; c < FRAME + 4; c++) begin
            @(negedge port_clk);
            busy_cnt += int'(busy); sync_cnt += int'(slot_sync);
        end
        total_cnt++; if (busy_cnt != FRAME || sync_cnt != 1)
            $display("FAIL oneshot_len got=%0d/%0d exp=%0d/1", busy_cnt, sync_cnt, FRAME);
        else pass_cnt++;
        frames_m += 1;
        host_read(A_CTRL, d, v);
        total_cnt++; if (d !== 8'h00) $display("FAIL oneshot_clr got=%h exp=00", d); else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [7:0] d; logic v;
        int need, cc, sync_cnt = 0;
        need = 256 - (frames_m % 256);
        cc = (need - 1) * FRAME + 10;
        host_write(A_CTRL, 8'h01);
        for (int c = 0; c <= cc; c++) begin
            @(negedge port_clk);
            host_wr = 1'b0;
            sync_cnt += int'(slot_sync);
            if (c == cc) begin host_addr = A_CTRL; host_wdata = 8'h00; host_wr = 1'b1; end
        end
        for (int w = 0; w < 2 * FRAME; w++) begin
            @(negedge port_clk);
            host_wr = 1'b0;
            sync_cnt += int'(slot_sync);
            if (!busy) break;
        end
        total_cnt++; if (busy !== 1'b0 || sync_cnt != need)
            $display("FAIL wrap_frames got=%0d/%b exp=%0d/0", sync_cnt, busy, need);
        else pass_cnt++;
        frames_m += need;
        host_read(A_FCNT, d, v);
        total_cnt++; if (d !== 8'(frames_m))
            $display("FAIL wrap_cnt got=%h exp=%h", d, 8'(frames_m));
        else pass_cnt++;
    endtask

    task automatic test_port_reset();
        logic [7:0] d; logic v;
        host_write(A_CTRL, 8'h01);
        repeat (20) @(negedge port_clk);
        total_cnt++; if (bus_oe !== 1'b1 || busy !== 1'b1)
            $display("FAIL pre_reset got=%b%b exp=11", bus_oe, busy);
        else pass_cnt++;
        port_rst = 1'b1;
        @(negedge port_clk);
        port_rst = 1'b0;
        total_cnt++; if ({bus_oe, slot_sync, busy, host_rvalid, bus_dout, host_rdata} !== 20'h0)
            $display("FAIL mid_reset got=%h exp=00000",
                     {bus_oe, slot_sync, busy, host_rvalid, bus_dout, host_rdata});
        else pass_cnt++;
        for (int p = 0; p < NPORTS; p++) begin dir_m[p] = 0; out_m[p] = 0; in_m[p] = 0; end
        frames_m = 0;
        host_read(AW'(0), d, v);
        total_cnt++; if (d !== 8'h00) $display("FAIL reset_dir got=%h exp=00", d); else pass_cnt++;
        host_read(AW'(2), d, v);
        total_cnt++; if (d !== 8'h00) $display("FAIL reset_in got=%h exp=00", d); else pass_cnt++;
        host_read(A_FCNT, d, v);
        total_cnt++; if (d !== 8'h00) $display("FAIL reset_fcnt2 got=%h exp=00", d); else pass_cnt++;
    endtask

`ifdef PORT_IO_CHANGE_IRQ_EN
    task automatic test_change();
        logic [7:0] d; logic v;
        host_write(A_CTRL, 8'h01);
        for (int c = 0; c < 3 * FRAME + 2; c++) begin
            @(negedge port_clk);
            host_wr = 1'b0;
            if (c == 2 * FRAME) begin
                total_cnt++; if (irq !== 1'b0) $display("FAIL chg_first got=%b exp=0", irq);
                else pass_cnt++;
            end
            if (c == 3 * FRAME + 1) begin
                total_cnt++; if (irq !== 1'b1) $display("FAIL chg_irq got=%b exp=1", irq);
                else pass_cnt++;
            end
            bus_din = 8'h00;
            if (c % FRAME == 12) bus_din = (c / FRAME == 2) ? 8'h5B : 8'h5A;
            if (c == 2 * FRAME + 20) begin host_addr = A_CTRL; host_wdata = 8'h00; host_wr = 1; end
        end
        frames_m += 3;
        host_read(A_CHG, d, v);
        total_cnt++; if (d !== 8'h08) $display("FAIL chg_lo got=%h exp=08", d); else pass_cnt++;
        host_write(A_CHG, 8'h08);
        total_cnt++; if (irq !== 1'b0) $display("FAIL chg_clr_irq got=%b exp=0", irq);
        else pass_cnt++;
        host_read(A_CHG, d, v);
        total_cnt++; if (d !== 8'h00) $display("FAIL chg_clr got=%h exp=00", d); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_regs();
        test_frames();
        test_deferred();
        test_oneshot();
        test_wrap();
        test_port_reset();
`ifdef PORT_IO_CHANGE_IRQ_EN
        test_change();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
